// File: rtl/key_event_gen.sv
// Key event generator: turns a debounced key level into press, release, short-click,
// long-press and auto-repeat pulses, plus a hold flag and a saturating repeat counter.
module key_event_gen #(
  parameter int LONG_CYC   = 100_000_000,
  parameter int REPEAT_CYC = 20_000_000,
  parameter int CNT_W      = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_lvl,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] repeat_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             armed;

  // NOTE: all state and outputs share one clocked block with non-blocking assignments,
  // so every decision below sees the values from before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      armed         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
      repeat_cnt    <= '0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      // A key held through reset must be seen released once before it counts.
      armed         <= armed | ~key_lvl;

      unique case (state)
        IDLE: begin
          if (key_lvl && armed) begin
            press_pulse <= 1'b1;
            cnt         <= '0;
            repeat_cnt  <= '0;
            held        <= 1'b1;
            state       <= HELD;
          end
        end

        HELD: begin
          if (!key_lvl) begin
            release_pulse <= 1'b1;
            short_pulse   <= 1'b1;
            held          <= 1'b0;
            state         <= IDLE;
          end else if (cnt == LONG_LAST) begin
            long_pulse <= 1'b1;
            cnt        <= '0;
            state      <= REPEAT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        REPEAT: begin
          if (!key_lvl) begin
            release_pulse <= 1'b1;
            held          <= 1'b0;
            state         <= IDLE;
          end else if (cnt == REPEAT_LAST) begin
            repeat_pulse <= 1'b1;
            cnt          <= '0;
            if (repeat_cnt != 8'hFF) repeat_cnt <= repeat_cnt + 8'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          held  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_gen.sv
// Scoreboard bench for key_event_gen: a hold-duration reference model queues expected
// pulse events, and a monitor on the falling edge pops and compares them.
module tb_key_event_gen;

  localparam int LONG_CYC   = 10;
  localparam int REPEAT_CYC = 4;
  localparam int CNT_W      = 8;

  logic       clk;
  logic       rst_n;
  logic       key_lvl;
  logic       press_pulse;
  logic       release_pulse;
  logic       short_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  logic       held;
  logic [7:0] repeat_cnt;

  key_event_gen #(
    .LONG_CYC  (LONG_CYC),
    .REPEAT_CYC(REPEAT_CYC),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_lvl      (key_lvl),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held),
    .repeat_cnt   (repeat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse vector order: {press, release, short, long, repeat}
  typedef struct {
    int         stamp;
    logic [4:0] pulses;
    logic [7:0] rcnt;
  } evt_t;

  evt_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   ncyc  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", name, ncyc, got, exp);
    end
  endtask

  // Reference model: tracks how many cycles the current accepted press has lasted and
  // derives every event from that duration directly.
  bit   m_armed;
  bit   m_active;
  int   m_hold;
  int   m_rcnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_armed  = 1'b0;
      m_active = 1'b0;
      m_hold   = 0;
      m_rcnt   = 0;
      q.delete();
    end else begin
      evt_t       e;
      logic [4:0] p;
      p = 5'b0;
      if (!m_active) begin
        if (key_lvl && m_armed) begin
          p[4]     = 1'b1;
          m_active = 1'b1;
          m_hold   = 0;
          m_rcnt   = 0;
        end
      end else if (!key_lvl) begin
        p[3]     = 1'b1;
        p[2]     = (m_hold < LONG_CYC);
        m_active = 1'b0;
      end else begin
        m_hold++;
        if (m_hold == LONG_CYC) begin
          p[1] = 1'b1;
        end else if (m_hold > LONG_CYC && (m_hold - LONG_CYC) % REPEAT_CYC == 0) begin
          p[0]   = 1'b1;
          m_rcnt = (m_rcnt < 255) ? m_rcnt + 1 : 255;
        end
      end
      if (!key_lvl) m_armed = 1'b1;
      if (p != 5'b0) begin
        e.stamp  = ncyc + 1;
        e.pulses = p;
        e.rcnt   = 8'(m_rcnt);
        q.push_back(e);
      end
    end
  end

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [4:0] pulses;
    evt_t       e;
    ncyc++;
    pulses = {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse};
    if (!rst_n) begin
      check("reset_outputs", {pulses, held, repeat_cnt}, 32'h0);
    end else begin
      while (q.size() != 0 && q[0].stamp < ncyc) begin
        e = q.pop_front();
        check("missed_event", 32'h0, 32'(e.pulses));
      end
      if (pulses != 5'b0) begin
        if (q.size() == 0) begin
          check("spurious_pulse", 32'(pulses), 32'h0);
        end else begin
          e = q.pop_front();
          check("event_time", ncyc, e.stamp);
          check("event_pulses", 32'(pulses), 32'(e.pulses));
          check("event_rcnt", 32'(repeat_cnt), 32'(e.rcnt));
        end
      end
      check("held", 32'(held), 32'(m_active));
      check("repeat_cnt", 32'(repeat_cnt), 32'(m_rcnt));
    end
  end

  task automatic hold(input logic v, input int n);
    key_lvl = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    key_lvl = 1'b0;
    #1;
    check("reset_async_press", 32'(press_pulse), 32'h0);
    check("reset_async_held", 32'(held), 32'h0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;

    // Short click
    hold(0, 3); hold(1, 3); hold(0, 3);
    // Long hold with three repeats
    hold(1, 25); hold(0, 3);
    // Release exactly on the long threshold edge
    hold(1, 10); hold(0, 3);
    // Repeat counter saturation, then a fresh press clears it
    hold(1, LONG_CYC + REPEAT_CYC * 260); hold(0, 2);
    check("sat_kept", 32'(repeat_cnt), 32'd255);
    hold(1, 2); hold(0, 2);
    check("sat_cleared", 32'(repeat_cnt), 32'd0);
    // Reset mid-hold while repeating, key kept high afterwards
    hold(1, 20);
    rst_n = 1'b0;
    #1;
    check("midhold_reset_held", 32'(held), 32'h0);
    hold(1, 2);
    rst_n = 1'b1;
    hold(1, 20);
    check("no_rearm_held", 32'(held), 32'h0);
    hold(0, 1); hold(1, 3); hold(0, 2);
    // Back-to-back single-cycle presses
    hold(1, 1); hold(0, 1); hold(1, 1); hold(0, 3);
    // Random key activity
    for (int i = 0; i < 300; i++) begin
      hold(1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 40))
                                       : int'($urandom_range(1, 6)));
    end
    hold(0, 4);
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
